// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 control path and datapath decoders.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Encoding is visible on the debug display, so values are fixed.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        ALU_WB    = 4'd9,
        BRANCH    = 4'd10,
        TRAP      = 4'd11
    } ctrlState_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32 datapath: sequencing, single-step,
// retired-instruction counter and sticky illegal-opcode trap.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        run,
    input  logic        step,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        branchNe,
    output logic        pcSource,
    output logic        irWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        memToReg,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic        instrDone,
    output logic        illegal,
    output logic [15:0] retired,
    output logic [3:0]  state
);

    ctrlState_t curState, nextState;
    logic [3:0] waitCnt;
    logic       lastWait;
    logic       inMemWait;

    assign lastWait  = (waitCnt == MEM_WAIT[3:0]);
    assign inMemWait = (curState == MEM_READ) || (curState == MEM_WRITE);
    assign state     = curState;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
            waitCnt  <= 4'd0;
            retired  <= 16'd0;
            illegal  <= 1'b0;
        end else begin
            curState <= nextState;
            waitCnt  <= (inMemWait && !lastWait) ? waitCnt + 4'd1 : 4'd0;
            if (instrDone)
                retired <= retired + 16'd1;
            if (nextState == TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nextState   = curState;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        branchNe    = 1'b0;
        pcSource    = 1'b0;
        irWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_RS2;
        aluOp       = ALUOP_ADD;
        instrDone   = 1'b0;
        case (curState)
            IDLE: begin
                if (run || step)
                    nextState = FETCH;
            end
            FETCH: begin
                memRead   = 1'b1;
                irWrite   = 1'b1;
                pcWrite   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                nextState = DECODE;
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                aluSrcB = SRCB_IMM;
                if (opcode == OP_LOAD || opcode == OP_STORE)
                    nextState = MEM_ADDR;
                else if (opcode == OP_RTYPE)
                    nextState = EXEC_R;
                else if (opcode == OP_IMM)
                    nextState = EXEC_I;
                else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00)
                    nextState = BRANCH;
                else
                    nextState = TRAP;
            end
            MEM_ADDR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_IMM;
                nextState = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                memRead = 1'b1;
                if (lastWait)
                    nextState = MEM_WB;
            end
            MEM_WB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            MEM_WRITE: begin
                memWrite  = 1'b1;
                instrDone = lastWait;
            end
            EXEC_R: begin
                aluSrcA   = 1'b1;
                aluOp     = ALUOP_FUNCT;
                nextState = ALU_WB;
            end
            EXEC_I: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_IMM;
                nextState = ALU_WB;
            end
            ALU_WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 1'b1;
                branchNe    = funct3[0];
                instrDone   = 1'b1;
            end
            TRAP: nextState = TRAP;
            default: nextState = IDLE;
        endcase
        // Every completing state shares the same exit rule.
        if (instrDone)
            nextState = run ? FETCH : IDLE;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control with two memory wait cycles.
module tb_multicycle_control;
    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        run;
    logic        step;
    logic        pcWrite, pcWriteCond, branchNe, pcSource, irWrite, memRead, memWrite;
    logic        regWrite, memToReg, aluSrcA, instrDone, illegal;
    logic [1:0]  aluSrcB, aluOp;
    logic [15:0] retired;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MEM_WAIT(2)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .run(run), .step(step), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .branchNe(branchNe), .pcSource(pcSource), .irWrite(irWrite),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .instrDone(instrDone), .illegal(illegal), .retired(retired), .state(state)
    );

    always #5 clock = ~clock;

    // Packed order: pcWrite pcWriteCond branchNe pcSource | irWrite memRead memWrite
    // regWrite | memToReg aluSrcA aluSrcB[1:0] | aluOp[1:0] instrDone illegal
    localparam logic [15:0] O_IDLE = 16'h0000;
    localparam logic [15:0] O_FET  = 16'h8C10;
    localparam logic [15:0] O_DEC  = 16'h0020;
    localparam logic [15:0] O_ADR  = 16'h0060;
    localparam logic [15:0] O_EXI  = 16'h0060;
    localparam logic [15:0] O_MRD  = 16'h0400;
    localparam logic [15:0] O_MWB  = 16'h0182;
    localparam logic [15:0] O_MWR  = 16'h0200;
    localparam logic [15:0] O_MWRD = 16'h0202;
    localparam logic [15:0] O_EXR  = 16'h0048;
    localparam logic [15:0] O_AWB  = 16'h0102;
    localparam logic [15:0] O_BEQ  = 16'h5046;
    localparam logic [15:0] O_BNE  = 16'h7046;
    localparam logic [15:0] O_TRAP = 16'h0001;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] AI = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        run;
        logic        step;
        logic [3:0]  st;
        logic [15:0] out;
        logic [15:0] ret;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic r, logic s,
                                logic [3:0] st, logic [15:0] out, logic [15:0] ret);
        vec_t v;
        v.op = op; v.f3 = f3; v.run = r; v.step = s; v.st = st; v.out = out; v.ret = ret;
        return v;
    endfunction

    function automatic logic [15:0] packOuts();
        return {pcWrite, pcWriteCond, branchNe, pcSource, irWrite, memRead, memWrite,
                regWrite, memToReg, aluSrcA, aluSrcB, aluOp, instrDone, illegal};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic waitState(input logic [3:0] target, input string name);
        int n = 0;
        while (state != target && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(name, {12'd0, state}, {12'd0, target});
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; run = 1'b0; step = 1'b0;

        vecs[0]  = mk(R,  3'b000, 1, 0, 4'd0,  O_IDLE, 16'd0);
        vecs[1]  = mk(R,  3'b000, 1, 0, 4'd1,  O_FET,  16'd0);
        vecs[2]  = mk(R,  3'b000, 1, 0, 4'd2,  O_DEC,  16'd0);
        vecs[3]  = mk(R,  3'b000, 1, 0, 4'd7,  O_EXR,  16'd0);
        vecs[4]  = mk(R,  3'b000, 1, 0, 4'd9,  O_AWB,  16'd0);
        vecs[5]  = mk(AI, 3'b000, 1, 0, 4'd1,  O_FET,  16'd1);
        vecs[6]  = mk(AI, 3'b000, 1, 0, 4'd2,  O_DEC,  16'd1);
        vecs[7]  = mk(AI, 3'b000, 1, 0, 4'd8,  O_EXI,  16'd1);
        vecs[8]  = mk(AI, 3'b000, 1, 0, 4'd9,  O_AWB,  16'd1);
        vecs[9]  = mk(LW, 3'b010, 1, 0, 4'd1,  O_FET,  16'd2);
        vecs[10] = mk(LW, 3'b010, 1, 0, 4'd2,  O_DEC,  16'd2);
        vecs[11] = mk(LW, 3'b010, 1, 0, 4'd3,  O_ADR,  16'd2);
        vecs[12] = mk(LW, 3'b010, 1, 0, 4'd4,  O_MRD,  16'd2);
        vecs[13] = mk(LW, 3'b010, 1, 0, 4'd4,  O_MRD,  16'd2);
        vecs[14] = mk(LW, 3'b010, 1, 0, 4'd4,  O_MRD,  16'd2);
        vecs[15] = mk(LW, 3'b010, 1, 0, 4'd5,  O_MWB,  16'd2);
        vecs[16] = mk(SW, 3'b010, 1, 0, 4'd1,  O_FET,  16'd3);
        vecs[17] = mk(SW, 3'b010, 1, 0, 4'd2,  O_DEC,  16'd3);
        vecs[18] = mk(SW, 3'b010, 1, 0, 4'd3,  O_ADR,  16'd3);
        vecs[19] = mk(SW, 3'b010, 1, 0, 4'd6,  O_MWR,  16'd3);
        vecs[20] = mk(SW, 3'b010, 1, 0, 4'd6,  O_MWR,  16'd3);
        vecs[21] = mk(SW, 3'b010, 1, 0, 4'd6,  O_MWRD, 16'd3);
        vecs[22] = mk(BR, 3'b000, 1, 0, 4'd1,  O_FET,  16'd4);
        vecs[23] = mk(BR, 3'b000, 0, 0, 4'd2,  O_DEC,  16'd4);
        vecs[24] = mk(BR, 3'b000, 0, 0, 4'd10, O_BEQ,  16'd4);
        vecs[25] = mk(BR, 3'b001, 0, 1, 4'd0,  O_IDLE, 16'd5);
        vecs[26] = mk(BR, 3'b001, 0, 0, 4'd1,  O_FET,  16'd5);
        vecs[27] = mk(BR, 3'b001, 0, 0, 4'd2,  O_DEC,  16'd5);
        vecs[28] = mk(BR, 3'b001, 0, 1, 4'd10, O_BNE,  16'd5);
        vecs[29] = mk(BR, 3'b001, 0, 0, 4'd0,  O_IDLE, 16'd6);
        vecs[30] = mk(BR, 3'b001, 0, 0, 4'd0,  O_IDLE, 16'd6);

        repeat (2) @(negedge clock);
        #1;
        check("reset_state", {12'd0, state}, 16'd0);
        check("reset_outs", packOuts(), O_IDLE);
        check("reset_retired", retired, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            opcode = vecs[i].op; funct3 = vecs[i].f3; run = vecs[i].run; step = vecs[i].step;
            #1;
            check($sformatf("vec%0d_state", i), {12'd0, state}, {12'd0, vecs[i].st});
            check($sformatf("vec%0d_outs", i), packOuts(), vecs[i].out);
            check($sformatf("vec%0d_retired", i), retired, vecs[i].ret);
        end

        // Unsupported opcode: trap is absorbing even with run held high.
        @(negedge clock);
        opcode = JL; funct3 = 3'b000; run = 1'b1;
        waitState(4'd11, "trap_enter");
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("trap%0d_state", i), {12'd0, state}, 16'd11);
            check($sformatf("trap%0d_outs", i), packOuts(), O_TRAP);
            check($sformatf("trap%0d_retired", i), retired, 16'd6);
        end
        #2 reset = 1'b1;
        #1;
        check("trap_reset_state", {12'd0, state}, 16'd0);
        check("trap_reset_illegal", {15'd0, illegal}, 16'd0);
        check("trap_reset_retired", retired, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        // Branch opcode with an unsupported funct3 also traps.
        opcode = BR; funct3 = 3'b100; run = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("badbr_state", {12'd0, state}, 16'd11);
        check("badbr_illegal", {15'd0, illegal}, 16'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous reset landing in the middle of an R-type.
        opcode = AI; run = 1'b1;
        waitState(4'd9, "async_addi_wb");
        @(negedge clock);
        opcode = R;
        waitState(4'd7, "async_exec_r");
        #2 reset = 1'b1;
        #1;
        check("async_state", {12'd0, state}, 16'd0);
        check("async_outs", packOuts(), O_IDLE);
        check("async_retired", retired, 16'd0);
        @(negedge clock);
        reset = 1'b0; run = 1'b0;

        // Preload the counter just below wrap, then retire one addi by single-step.
        @(negedge clock);
        force dut.retired = 16'hFFFF;
        #1 release dut.retired;
        #1;
        check("wrap_preload", retired, 16'hFFFF);
        @(negedge clock);
        opcode = AI; step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        waitState(4'd9, "wrap_alu_wb");
        @(negedge clock);
        #1;
        check("wrap_retired", retired, 16'h0000);
        check("wrap_idle", {12'd0, state}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
